// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/execute/memory/writeback
// and drives the datapath enables. All outputs decode registered state only.
module core_sequencer #(
  parameter int IMEM_LATENCY = 1,
  parameter int DMEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic        branch_taken,
  output logic        imem_rd_en,
  output logic        ir_load,
  output logic        alu_en,
  output logic        dmem_rd_en,
  output logic        dmem_wren,
  output logic        rf_wr_en,
  output logic [1:0]  wb_sel,
  output logic        pc_load,
  output logic [1:0]  pc_sel,
  output logic        illegal_instr,
  output logic [31:0] instret
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Wait counters count down to zero, so they are loaded with latency-1.
  localparam logic [2:0] IWAIT_LOAD = 3'(IMEM_LATENCY - 1);
  localparam logic [2:0] DWAIT_LOAD = 3'(DMEM_LATENCY - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_IWAIT,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_DWAIT,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  wait_cnt_reg, wait_cnt_next;
  logic [31:0] instret_reg;
  logic        illegal_reg;

  // Instruction class captured in DECODE so later states never depend on live decoder inputs.
  logic load_reg, store_reg, branch_reg, jal_reg, jalr_reg, lui_reg, rf_write_reg;
  logic taken_reg;

  logic dec_legal, dec_load, dec_store, dec_branch, dec_jal, dec_jalr, dec_lui, dec_writes;

  always_comb begin
    dec_legal  = 1'b1;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_branch = 1'b0;
    dec_jal    = 1'b0;
    dec_jalr   = 1'b0;
    dec_lui    = 1'b0;
    dec_writes = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_AUIPC: dec_writes = 1'b1;
      OPC_LOAD: begin
        dec_load   = 1'b1;
        dec_writes = 1'b1;
      end
      OPC_STORE:  dec_store  = 1'b1;
      OPC_BRANCH: dec_branch = 1'b1;
      OPC_JAL: begin
        dec_jal    = 1'b1;
        dec_writes = 1'b1;
      end
      OPC_JALR: begin
        dec_jalr   = 1'b1;
        dec_writes = 1'b1;
      end
      OPC_LUI: begin
        dec_lui    = 1'b1;
        dec_writes = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: dec_legal = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 3'd0;
      instret_reg  <= 32'd0;
      illegal_reg  <= 1'b0;
      load_reg     <= 1'b0;
      store_reg    <= 1'b0;
      branch_reg   <= 1'b0;
      jal_reg      <= 1'b0;
      jalr_reg     <= 1'b0;
      lui_reg      <= 1'b0;
      rf_write_reg <= 1'b0;
      taken_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == S_DECODE) begin
        load_reg     <= dec_load;
        store_reg    <= dec_store;
        branch_reg   <= dec_branch;
        jal_reg      <= dec_jal;
        jalr_reg     <= dec_jalr;
        lui_reg      <= dec_lui;
        rf_write_reg <= dec_writes && (rd != 5'd0);
        if (!dec_legal) illegal_reg <= 1'b1;
      end
      if (state_reg == S_EXECUTE) taken_reg <= branch_taken;
      if (state_reg == S_WRITEBACK) instret_reg <= instret_reg + 32'd1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      S_IDLE: if (run) state_next = S_FETCH;
      S_FETCH: begin
        state_next    = S_IWAIT;
        wait_cnt_next = IWAIT_LOAD;
      end
      S_IWAIT: begin
        if (wait_cnt_reg == 3'd0) state_next = S_DECODE;
        else wait_cnt_next = wait_cnt_reg - 3'd1;
      end
      S_DECODE:  state_next = dec_legal ? S_EXECUTE : S_HALT;
      S_EXECUTE: state_next = (load_reg || store_reg) ? S_MEM : S_WRITEBACK;
      S_MEM: begin
        if (store_reg) begin
          state_next = S_WRITEBACK;
        end else begin
          state_next    = S_DWAIT;
          wait_cnt_next = DWAIT_LOAD;
        end
      end
      S_DWAIT: begin
        if (wait_cnt_reg == 3'd0) state_next = S_WRITEBACK;
        else wait_cnt_next = wait_cnt_reg - 3'd1;
      end
      S_WRITEBACK: state_next = run ? S_FETCH : S_IDLE;
      S_HALT:      state_next = S_HALT;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_rd_en = 1'b0;
    ir_load    = 1'b0;
    alu_en     = 1'b0;
    dmem_rd_en = 1'b0;
    dmem_wren  = 1'b0;
    rf_wr_en   = 1'b0;
    wb_sel     = 2'b00;
    pc_load    = 1'b0;
    pc_sel     = 2'b00;
    case (state_reg)
      S_FETCH:   imem_rd_en = 1'b1;
      S_IWAIT:   ir_load    = (wait_cnt_reg == 3'd0);
      S_EXECUTE: alu_en     = 1'b1;
      S_MEM: begin
        dmem_wren  = store_reg;
        dmem_rd_en = load_reg;
      end
      S_WRITEBACK: begin
        pc_load  = 1'b1;
        rf_wr_en = rf_write_reg;
        if (load_reg)                 wb_sel = 2'b01;
        else if (jal_reg || jalr_reg) wb_sel = 2'b10;
        else if (lui_reg)             wb_sel = 2'b11;
        if (jalr_reg)                               pc_sel = 2'b10;
        else if (jal_reg || (branch_reg && taken_reg)) pc_sel = 2'b01;
      end
      default: ;
    endcase
  end

  assign illegal_instr = illegal_reg;
  assign instret       = instret_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus pushes expected output events, a negedge
// monitor pops and compares each cycle in which the DUT asserts any strobe.
module tb_core_sequencer;

  localparam int IMEM_LAT = 1;
  localparam int DMEM_LAT = 3;

  localparam logic [6:0] S_IMEM = 7'b1000000;
  localparam logic [6:0] S_IR   = 7'b0100000;
  localparam logic [6:0] S_ALU  = 7'b0010000;
  localparam logic [6:0] S_DRD  = 7'b0001000;
  localparam logic [6:0] S_DWR  = 7'b0000100;
  localparam logic [6:0] S_RF   = 7'b0000010;
  localparam logic [6:0] S_PC   = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [4:0]  rd = 5'd0;
  logic        branch_taken = 1'b0;
  logic        imem_rd_en, ir_load, alu_en, dmem_rd_en, dmem_wren, rf_wr_en, pc_load;
  logic [1:0]  wb_sel, pc_sel;
  logic        illegal_instr;
  logic [31:0] instret;

  core_sequencer #(.IMEM_LATENCY(IMEM_LAT), .DMEM_LATENCY(DMEM_LAT)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .rd(rd),
    .branch_taken(branch_taken), .imem_rd_en(imem_rd_en), .ir_load(ir_load),
    .alu_en(alu_en), .dmem_rd_en(dmem_rd_en), .dmem_wren(dmem_wren),
    .rf_wr_en(rf_wr_en), .wb_sel(wb_sel), .pc_load(pc_load), .pc_sel(pc_sel),
    .illegal_instr(illegal_instr), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  strobes;
    logic [1:0]  wb;
    logic [1:0]  pc;
    int          gap;
    logic [31:0] instret;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = 32'd0;
  int          cycle = 0;
  int          last_ev = 0;

  // Monitor: one comparison per strobe cycle, including timing relative to the previous event.
  always @(negedge clk) begin
    logic [6:0] s;
    ev_t        e;
    cycle = cycle + 1;
    s = {imem_rd_en, ir_load, alu_en, dmem_rd_en, dmem_wren, rf_wr_en, pc_load};
    if (s != 7'd0) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_event cycle=%0d actual strobes=%b wb=%b pc=%b required no event",
                 cycle, s, wb_sel, pc_sel);
      end else begin
        e = exp_q.pop_front();
        if (s !== e.strobes || wb_sel !== e.wb || pc_sel !== e.pc ||
            (e.gap >= 0 && (cycle - last_ev) != e.gap) || instret !== e.instret) begin
          errors = errors + 1;
          $display("FAIL event cycle=%0d actual strobes=%b wb=%b pc=%b gap=%0d instret=%0h required strobes=%b wb=%b pc=%b gap=%0d instret=%0h",
                   cycle, s, wb_sel, pc_sel, cycle - last_ev, instret,
                   e.strobes, e.wb, e.pc, e.gap, e.instret);
        end else begin
          $display("event cycle=%0d strobes=%b wb=%b pc=%b instret=%0h ok", cycle, s, wb_sel, pc_sel, instret);
        end
      end
      last_ev = cycle;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  function automatic void push(input logic [6:0] s, input logic [1:0] w, input logic [1:0] p,
                               input int g, input logic [31:0] ir);
    ev_t e;
    e.strobes = s;
    e.wb      = w;
    e.pc      = p;
    e.gap     = g;
    e.instret = ir;
    exp_q.push_back(e);
  endfunction

  function automatic logic [31:0] all_outs();
    return {17'd0, imem_rd_en, ir_load, alu_en, dmem_rd_en, dmem_wren, rf_wr_en,
            pc_load, wb_sel, pc_sel, illegal_instr};
  endfunction

  // kind: 0 = no memory phase, 1 = load, 2 = store. Called at a negedge with the FSM in IDLE,
  // or in WRITEBACK of the previous instruction when chaining.
  task automatic exec_one(input string name, input logic [6:0] op, input logic [4:0] r,
                          input logic taken, input int kind, input logic rf,
                          input logic [1:0] w, input logic [1:0] p,
                          input logic chain, input int first_gap);
    logic clr;
    logic done;
    push(S_IMEM, 2'b00, 2'b00, first_gap, exp_instret);
    push(S_IR, 2'b00, 2'b00, IMEM_LAT, exp_instret);
    push(S_ALU, 2'b00, 2'b00, 2, exp_instret);
    if (kind == 1) push(S_DRD, 2'b00, 2'b00, 1, exp_instret);
    if (kind == 2) push(S_DWR, 2'b00, 2'b00, 1, exp_instret);
    push(S_PC | (rf ? S_RF : 7'd0), w, p, (kind == 1) ? DMEM_LAT + 1 : 1, exp_instret);
    exp_instret = exp_instret + 32'd1;
    $display("issue %s opcode=%b rd=%0d taken=%0d", name, op, r, taken);
    opcode = op;
    rd = r;
    branch_taken = taken;
    run = 1'b1;
    @(negedge clk);
    run = chain;
    clr = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (clr) branch_taken = 1'b0;
      if (alu_en === 1'b1) clr = 1'b1;
      if (pc_load === 1'b1) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s_wb_timeout actual=no pc_load required=pc_load within 40 cycles", name);
    end
    if (!chain) begin
      @(negedge clk);
      chk({name, "_instret"}, instret, exp_instret);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic done;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 32'd0);
    chk("reset_instret", instret, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", all_outs(), 32'd0);

    exec_one("addi_x1", 7'b0010011, 5'd1, 1'b0, 0, 1'b1, 2'b00, 2'b00, 1'b0, -1);
    exec_one("addi_b2b_a", 7'b0010011, 5'd2, 1'b0, 0, 1'b1, 2'b00, 2'b00, 1'b1, -1);
    exec_one("addi_b2b_b", 7'b0010011, 5'd3, 1'b0, 0, 1'b1, 2'b00, 2'b00, 1'b0, 1);
    exec_one("lw_x5", 7'b0000011, 5'd5, 1'b0, 1, 1'b1, 2'b01, 2'b00, 1'b0, -1);
    exec_one("beq_taken", 7'b1100011, 5'd3, 1'b1, 0, 1'b0, 2'b00, 2'b01, 1'b0, -1);
    exec_one("beq_not", 7'b1100011, 5'd3, 1'b0, 0, 1'b0, 2'b00, 2'b00, 1'b0, -1);
    exec_one("add_x0", 7'b0110011, 5'd0, 1'b0, 0, 1'b0, 2'b00, 2'b00, 1'b0, -1);
    exec_one("sw", 7'b0100011, 5'd7, 1'b0, 2, 1'b0, 2'b00, 2'b00, 1'b0, -1);
    exec_one("jal_x1", 7'b1101111, 5'd1, 1'b0, 0, 1'b1, 2'b10, 2'b01, 1'b0, -1);
    exec_one("jalr_x2", 7'b1100111, 5'd2, 1'b0, 0, 1'b1, 2'b10, 2'b10, 1'b0, -1);
    exec_one("lui_x3", 7'b0110111, 5'd3, 1'b0, 0, 1'b1, 2'b11, 2'b00, 1'b0, -1);
    exec_one("auipc_x4", 7'b0010111, 5'd4, 1'b0, 0, 1'b1, 2'b00, 2'b00, 1'b0, -1);
    exec_one("fence", 7'b0001111, 5'd0, 1'b0, 0, 1'b0, 2'b00, 2'b00, 1'b0, -1);
    exec_one("system", 7'b1110011, 5'd5, 1'b0, 0, 1'b0, 2'b00, 2'b00, 1'b0, -1);

    // Load aborted by reset while waiting for data.
    push(S_IMEM, 2'b00, 2'b00, -1, exp_instret);
    push(S_IR, 2'b00, 2'b00, IMEM_LAT, exp_instret);
    push(S_ALU, 2'b00, 2'b00, 2, exp_instret);
    push(S_DRD, 2'b00, 2'b00, 1, exp_instret);
    $display("issue lw_reset opcode=0000011 rd=5");
    opcode = 7'b0000011;
    rd = 5'd5;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (dmem_rd_en === 1'b1) done = 1'b1;
      else @(negedge clk);
    end
    chk("lw_reset_mem_reached", {31'd0, done}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_dwait_outputs", all_outs(), 32'd0);
    chk("reset_dwait_instret", instret, 32'd0);
    reset = 1'b0;
    exp_instret = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_dwait_queue_empty", exp_q.size(), 32'd0);

    // Counter wrap.
    dut.instret_reg = 32'hFFFF_FFFF;
    exp_instret = 32'hFFFF_FFFF;
    @(negedge clk);
    exec_one("addi_wrap", 7'b0010011, 5'd1, 1'b0, 0, 1'b1, 2'b00, 2'b00, 1'b0, -1);

    // Illegal opcode halts until reset.
    push(S_IMEM, 2'b00, 2'b00, -1, exp_instret);
    push(S_IR, 2'b00, 2'b00, IMEM_LAT, exp_instret);
    $display("issue illegal opcode=1111111");
    opcode = 7'b1111111;
    rd = 5'd1;
    run = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (illegal_instr === 1'b1) done = 1'b1;
    end
    chk("illegal_set", {31'd0, illegal_instr}, 32'd1);
    repeat (100) @(negedge clk);
    chk("halt_illegal_sticky", {31'd0, illegal_instr}, 32'd1);
    chk("halt_instret", instret, exp_instret);
    chk("halt_queue_empty", exp_q.size(), 32'd0);
    run = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_instret = 32'd0;
    @(negedge clk);
    chk("post_halt_reset_outputs", all_outs(), 32'd0);
    chk("post_halt_instret", instret, 32'd0);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
